// File: rtl/mont_mul_iter_pkg.sv
// Shared constants, helper functions and FSM encoding for the iterative
// Montgomery multiplier.
package mont_mul_iter_pkg;

    // Curve25519 field prime 2^255-19
    localparam logic [254:0] Q_25519 =
        255'h7fffffff_ffffffff_ffffffff_ffffffff_ffffffff_ffffffff_ffffffff_ffffffed;

    typedef enum logic [1:0] {IDLE, CALC, CORR, DONE} state_t;

    function automatic int ceil_div(input int a, input int b);
        return (a + b - 1) / b;
    endfunction

    // -q^-1 mod 2^d for odd q, d <= 32. Newton iteration on the inverse:
    // q*q == 1 mod 8 seeds 3 correct bits, each step doubles them (3->48).
    function automatic logic [31:0] calc_qprime(input logic [31:0] q, input int d);
        logic [31:0] inv;
        logic [31:0] mask;
        inv = q;
        for (int i = 0; i < 4; i++) begin
            inv = inv * (32'd2 - q * inv);
        end
        mask = (d >= 32) ? 32'hffff_ffff : ((32'd1 << d) - 32'd1);
        return (32'd0 - inv) & mask;
    endfunction

endpackage

// File: rtl/mont_mul_iter_if.sv
// Operand/result valid-ready bundle of the Montgomery multiplier.
interface mont_mul_iter_if #(
    parameter int N = 255
);
    logic         i_valid;
    logic         o_ready;
    logic [N-1:0] i_x;
    logic [N-1:0] i_y;
    logic         o_valid;
    logic         i_ready;
    logic [N-1:0] o_result;
    logic         o_range_err;

    modport slave (
        input  i_valid, i_x, i_y, i_ready,
        output o_ready, o_valid, o_result, o_range_err
    );

    modport master (
        output i_valid, i_x, i_y, i_ready,
        input  o_ready, o_valid, o_result, o_range_err
    );
endinterface

// File: rtl/mont_mul_iter_digit_step.sv
// One digit-serial Montgomery reduction step:
//   T1 = T + xd*y ; m = T1*QP mod 2^D ; T' = (T1 + m*Q) >> D
// With T < 2Q and xd*y < 2^D*Q, the sum stays below 2Q*(2^D+1), so
// N+D+2 bits hold it and the shifted result again fits N+1 bits.
module mont_mul_iter_digit_step #(
    parameter int           N  = 255,
    parameter int           D  = 17,
    parameter logic [N-1:0] Q  = '1,
    parameter logic [D-1:0] QP = '1
) (
    input  logic [N:0]   t,
    input  logic [D-1:0] xd,
    input  logic [N-1:0] y,
    output logic [N:0]   t_nxt
);
    localparam int W = N + D + 2;

    logic [W-1:0] t1;
    logic [D-1:0] m;
    logic [W-1:0] s;

    assign t1    = W'(t) + W'(xd) * W'(y);
    assign m     = t1[D-1:0] * QP;
    assign s     = t1 + W'(m) * W'(Q);
    assign t_nxt = s[D +: N+1];
endmodule

// File: rtl/mont_mul_iter.sv
// Iterative digit-serial Montgomery multiplier: result = x*y*2^-(K*D) mod Q.
// One digit of x per clock, then a single conditional subtract.
module mont_mul_iter
    import mont_mul_iter_pkg::*;
#(
    parameter int           N = 255,
    parameter int           D = 17,
    parameter logic [N-1:0] Q = N'(Q_25519)
) (
    input  logic          i_clk,
    input  logic          i_rst_n,
    mont_mul_iter_if.slave bus
);
    localparam int           K  = ceil_div(N, D);
    localparam int           KD = K * D;
    localparam int           CW = (K > 1) ? $clog2(K) : 1;
    localparam logic [D-1:0] QP = D'(calc_qprime(32'(Q), D));

    state_t         state_q, state_d;
    logic [KD-1:0]  x_sh;      // remaining x digits, current digit at LSBs
    logic [N-1:0]   y_r;
    logic [N:0]     t_r, t_nxt;
    logic [N-1:0]   t_sub;
    logic [CW-1:0]  cnt;
    logic [N-1:0]   res_r;
    logic           err_r;
    logic           last;
    logic           accept;

    assign last   = (cnt == CW'(K - 1));
    assign accept = (state_q == IDLE) && bus.i_valid;
    // T < 2Q, so when T >= Q the low N bits of T-Q are exact
    assign t_sub  = t_r[N-1:0] - Q;

    mont_mul_iter_digit_step #(.N(N), .D(D), .Q(Q), .QP(QP)) u_step (
        .t     (t_r),
        .xd    (x_sh[D-1:0]),
        .y     (y_r),
        .t_nxt (t_nxt)
    );

    // State register
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) state_q <= IDLE;
        else          state_q <= state_d;
    end

    // Next-state: accept -> K iterations -> correction -> hold until drained
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (bus.i_valid) state_d = CALC;
            CALC:    if (last)        state_d = CORR;
            CORR:                     state_d = DONE;
            DONE:    if (bus.i_ready) state_d = IDLE;
            default:                  state_d = IDLE;
        endcase
    end

    // Operand latch, iteration datapath and result register
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            x_sh  <= '0;
            y_r   <= '0;
            t_r   <= '0;
            cnt   <= '0;
            res_r <= '0;
            err_r <= 1'b0;
        end else if (accept) begin
            x_sh  <= KD'(bus.i_x);
            y_r   <= bus.i_y;
            t_r   <= '0;
            cnt   <= '0;
            err_r <= (bus.i_x >= Q) || (bus.i_y >= Q);
        end else if (state_q == CALC) begin
            x_sh  <= x_sh >> D;
            t_r   <= t_nxt;
            cnt   <= cnt + CW'(1);
        end else if (state_q == CORR) begin
            res_r <= (t_r >= {1'b0, Q}) ? t_sub : t_r[N-1:0];
        end
    end

    assign bus.o_ready     = (state_q == IDLE);
    assign bus.o_valid     = (state_q == DONE);
    assign bus.o_result    = res_r;
    assign bus.o_range_err = err_r;
endmodule

// File: tb/tb_mont_mul_iter.sv
// Scoreboard bench for mont_mul_iter: directed cases plus random operands at
// D=17, D=5 and D=1 against a halving-based reference of x*y*2^-255 mod Q.
module tb_mont_mul_iter;
    import mont_mul_iter_pkg::*;

    localparam int           N  = 255;
    localparam int           D0 = 17;
    localparam int           K0 = (N + D0 - 1) / D0;
    localparam logic [N-1:0] Q  = Q_25519;

    typedef struct {
        logic [N-1:0] res;
        logic         err;
        bit           chk_res;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    bit   go = 1'b0;
    bit   done0 = 1'b0;
    int   ncmp = 0;
    int   nerr = 0;

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [N:0] act, input logic [N:0] exp);
        ncmp++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // x*y*2^-sh mod Q: reduce the product, then divide by 2 sh times mod Q
    function automatic logic [N-1:0] mref(input logic [N-1:0] x, input logic [N-1:0] y, input int sh);
        logic [2*N+1:0] a, b, qq, v;
        a = '0; b = '0; qq = '0;
        a[N-1:0] = x; b[N-1:0] = y; qq[N-1:0] = Q;
        v = (a * b) % qq;
        for (int i = 0; i < sh; i++) v = v[0] ? (v + qq) >> 1 : v >> 1;
        return v[N-1:0];
    endfunction

    function automatic logic [N-1:0] rnd_lt_q();
        logic [255:0] t;
        logic [N-1:0] r;
        for (int i = 0; i < 8; i++) t[i*32 +: 32] = $urandom;
        r = t[N-1:0];
        if (r >= Q) r = r - Q;
        case ($urandom_range(0, 15))
            0:       r = '0;
            1:       r = Q - 1;
            default: ;
        endcase
        return r;
    endfunction

    // ---------------- main DUT, D = 17 ----------------
    mont_mul_iter_if #(.N(N)) b0();
    mont_mul_iter #(.N(N), .D(D0), .Q(Q)) dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .bus     (b0)
    );

    exp_t q0[$];

    // Pop the expectation whenever a result is actually handed over
    always @(negedge clk) begin
        if (rst_n && b0.o_valid && b0.i_ready) begin
            if (q0.size() == 0) chk("unexpected_out_d17", 1, 0);
            else begin
                exp_t e;
                e = q0.pop_front();
                if (e.chk_res) chk("result_d17", b0.o_result, e.res);
                chk("range_err_d17", b0.o_range_err, e.err);
            end
        end
    end

    // Waits for o_ready, presents one operand pair, returns #1 after the accept edge
    task automatic send0(input logic [N-1:0] x, input logic [N-1:0] y, input exp_t e, input bit push);
        int n;
        n = 0;
        @(posedge clk); #1;
        while (!b0.o_ready && n < 2000) begin
            @(posedge clk); #1;
            n++;
        end
        if (!b0.o_ready) begin
            chk("ready_timeout_d17", 0, 1);
            return;
        end
        b0.i_valid = 1'b1; b0.i_x = x; b0.i_y = y;
        if (push) q0.push_back(e);
        @(posedge clk); #1;
        b0.i_valid = 1'b0;
        b0.i_x = rnd_lt_q(); b0.i_y = rnd_lt_q();
    endtask

    task automatic wait_idle0();
        int n;
        n = 0;
        @(negedge clk);
        while (!(b0.o_ready && q0.size() == 0) && n < 2000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 2000) chk("idle_timeout_d17", 0, 1);
    endtask

    // ---------------- random-only DUTs, D = 5 and D = 1 ----------------
    for (genvar g = 0; g < 2; g++) begin : g_rnd
        localparam int DG   = (g == 0) ? 5 : 1;
        localparam int KG   = (N + DG - 1) / DG;
        localparam int NOPS = (g == 0) ? 150 : 40;

        mont_mul_iter_if #(.N(N)) bus();
        mont_mul_iter #(.N(N), .D(DG), .Q(Q)) dut (
            .i_clk   (clk),
            .i_rst_n (rst_n),
            .bus     (bus)
        );

        exp_t q[$];
        bit   fin = 1'b0;

        // Stimulus: back-to-back random operands once the directed phase is over
        initial begin
            logic [N-1:0] x, y;
            int t;
            bus.i_valid = 1'b0; bus.i_x = '0; bus.i_y = '0; bus.i_ready = 1'b1;
            wait (go);
            for (int n = 0; n < NOPS; n++) begin
                x = rnd_lt_q(); y = rnd_lt_q();
                t = 0;
                @(posedge clk); #1;
                while (!bus.o_ready && t < 2000) begin
                    @(posedge clk); #1;
                    t++;
                end
                if (!bus.o_ready) begin
                    chk($sformatf("ready_timeout_d%0d", DG), 0, 1);
                    break;
                end
                bus.i_valid = 1'b1; bus.i_x = x; bus.i_y = y;
                q.push_back('{res: mref(x, y, KG * DG), err: 1'b0, chk_res: 1'b1});
                @(posedge clk); #1;
                bus.i_valid = 1'b0;
            end
            fin = 1'b1;
        end

        // Result checker
        always @(negedge clk) begin
            if (rst_n && bus.o_valid && bus.i_ready) begin
                if (q.size() == 0) chk($sformatf("unexpected_out_d%0d", DG), 1, 0);
                else begin
                    exp_t e;
                    e = q.pop_front();
                    chk($sformatf("result_d%0d", DG), bus.o_result, e.res);
                    chk($sformatf("range_err_d%0d", DG), bus.o_range_err, e.err);
                end
            end
        end
    end

    // Watchdog
    initial begin
        #3000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- directed sequence, then random phase ----------------
    initial begin
        exp_t e;
        logic [N-1:0] r0;
        int lat, n;

        b0.i_valid = 1'b0; b0.i_x = '0; b0.i_y = '0; b0.i_ready = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_ready", b0.o_ready, 1);
        chk("rst_valid", b0.o_valid, 0);
        chk("rst_result", b0.o_result, 0);
        chk("rst_range_err", b0.o_range_err, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;

        // 19 is R mod Q, so 19*y*R^-1 = y; also measure latency
        e = '{res: 12345, err: 1'b0, chk_res: 1'b1};
        send0(19, 12345, e, 1'b1);
        lat = 0;
        for (int c = 1; c <= 40; c++) begin
            @(posedge clk);
            @(negedge clk);
            if (b0.o_valid) begin
                lat = c;
                break;
            end
        end
        chk("latency", lat, K0 + 1);
        wait_idle0();

        // Zero operand and the largest in-range operand
        e = '{res: 0, err: 1'b0, chk_res: 1'b1};
        send0(0, Q - 1, e, 1'b1);
        e = '{res: Q - 1, err: 1'b0, chk_res: 1'b1};
        send0(19, Q - 1, e, 1'b1);
        wait_idle0();

        // Backpressure: result held, no new accept while DONE
        b0.i_ready = 1'b0;
        e = '{res: 777, err: 1'b0, chk_res: 1'b1};
        send0(19, 777, e, 1'b1);
        n = 0;
        @(negedge clk);
        while (!b0.o_valid && n < 40) begin
            @(negedge clk);
            n++;
        end
        chk("bp_valid_rise", b0.o_valid, 1);
        r0 = b0.o_result;
        for (int c = 0; c < 10; c++) begin
            @(posedge clk); #1;
            b0.i_valid = 1'b1; b0.i_x = rnd_lt_q(); b0.i_y = rnd_lt_q();
            @(negedge clk);
            chk("bp_valid_hold", b0.o_valid, 1);
            chk("bp_ready_low", b0.o_ready, 0);
            chk("bp_result_hold", b0.o_result, r0);
        end
        @(posedge clk); #1;
        b0.i_valid = 1'b0;
        b0.i_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("bp_valid_drop", b0.o_valid, 0);
        chk("bp_ready_back", b0.o_ready, 1);
        for (int c = 0; c < K0 + 4; c++) begin
            @(negedge clk);
            chk("bp_no_extra_op", b0.o_valid, 0);
        end

        // Reset during iteration 7 discards the op
        e = '{res: 0, err: 1'b0, chk_res: 1'b0};
        send0(19, 99, e, 1'b0);
        repeat (7) @(posedge clk);
        #1 rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        chk("midrst_ready", b0.o_ready, 1);
        for (int c = 0; c < K0 + 4; c++) begin
            @(negedge clk);
            chk("midrst_no_valid", b0.o_valid, 0);
        end

        // Out-of-range operand flags, next op clean
        e = '{res: 0, err: 1'b1, chk_res: 1'b0};
        send0(Q, 1, e, 1'b1);
        e = '{res: 5, err: 1'b0, chk_res: 1'b1};
        send0(19, 5, e, 1'b1);
        wait_idle0();

        // Random phase on all three instances in parallel
        go = 1'b1;
        fork
            begin
                logic [N-1:0] x, y;
                for (int i = 0; i < 300; i++) begin
                    x = rnd_lt_q(); y = rnd_lt_q();
                    e = '{res: mref(x, y, K0 * D0), err: 1'b0, chk_res: 1'b1};
                    send0(x, y, e, 1'b1);
                end
                wait_idle0();
                done0 = 1'b1;
            end
            begin
                while (!done0) begin
                    @(posedge clk); #1;
                    b0.i_ready = ($urandom_range(0, 3) != 0);
                end
                b0.i_ready = 1'b1;
            end
        join

        n = 0;
        while (!(g_rnd[0].fin && g_rnd[1].fin && g_rnd[0].q.size() == 0 && g_rnd[1].q.size() == 0)
               && n < 60000) begin
            @(negedge clk);
            n++;
        end
        chk("drain_d5", g_rnd[0].q.size(), 0);
        chk("drain_d1", g_rnd[1].q.size(), 0);
        chk("drain_d17", q0.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
        $finish;
    end
endmodule
